// File: rtl/data_bus_responder_pkg.sv
// Shared address map, status bit positions and UART transmitter state encoding
// for the CPU data-port responder.
package data_bus_responder_pkg;

  localparam logic [7:0] RAM_TOP        = 8'hEF;
  localparam logic [7:0] ADDR_UART_DATA = 8'hF0;
  localparam logic [7:0] ADDR_UART_STAT = 8'hF1;
  localparam logic [7:0] ADDR_GPIO      = 8'hF2;
  localparam int         RAM_WORDS      = int'(RAM_TOP) + 1;

  localparam int BUSY = 0;
  localparam int FULL = 1;
  localparam int OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/data_bus_responder_uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serialiser; a push into an idle, empty unit is popped next edge.
// A push while full with no pop that edge is dropped and flagged on ovf_evt.
module uart_tx_fifo
  import data_bus_responder_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push_vld,
  input  logic [7:0] push_dat,
  output logic       full,
  output logic       busy,
  output logic       ovf_evt,
  output logic       txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          empty, baud_done, pop, push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign baud_done = (baud_q == BAUD_LAST);
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign push_ok   = push_vld && (!full || pop);
  assign ovf_evt   = push_vld && full && !pop;
  assign txd       = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Line level is registered from the next state so it is glitch-free.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-port responder: RAM plus UART/GPIO registers, zero-cycle combinational reads.
// Never stalls the CPU; UART bytes written while the TX FIFO is full are dropped and flagged.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] w_data,
  input  logic       w_en,
  output logic [7:0] r_data,
  output logic       uart_txd,
  output logic [7:0] gpio_out
);

  logic [7:0] ram_q [RAM_WORDS];
  logic [7:0] gpio_q, gpio_d;
  logic       ovf_q, ovf_d;
  logic       ram_sel, tx_push, tx_full, tx_busy, ovf_evt;
  logic [7:0] status;

  assign ram_sel  = (addr <= RAM_TOP);
  assign tx_push  = w_en && (addr == ADDR_UART_DATA);
  assign gpio_out = gpio_q;

  uart_tx_fifo #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .push_vld(tx_push),
    .push_dat(w_data),
    .full    (tx_full),
    .busy    (tx_busy),
    .ovf_evt (ovf_evt),
    .txd     (uart_txd)
  );

  always_comb begin
    status       = 8'h00;
    status[BUSY] = tx_busy;
    status[FULL] = tx_full;
    status[OVF]  = ovf_q;
  end

  always_comb begin
    r_data = 8'h00;
    if (ram_sel) begin
      r_data = ram_q[addr];
    end else begin
      case (addr)
        ADDR_UART_STAT: r_data = status;
        ADDR_GPIO:      r_data = gpio_q;
        default:        r_data = 8'h00;
      endcase
    end
  end

  // A drop on the same edge as a clear must leave the sticky flag set.
  always_comb begin
    gpio_d = gpio_q;
    ovf_d  = ovf_q;
    if (w_en && (addr == ADDR_GPIO))      gpio_d = w_data;
    if (w_en && (addr == ADDR_UART_STAT)) ovf_d  = 1'b0;
    if (ovf_evt)                          ovf_d  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (w_en && ram_sel) ram_q[addr] <= w_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gpio_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Memory-side responder for the 8-bit pipelined CPU's data port.
- Takes the CPU's MEM-stage address, write data and write enable, and returns read data in the same cycle, because the CPU samples read data at the end of MEM.
- Address space: data RAM at 0x00–0xEF; memory-mapped I/O at 0xF0–0xFF (UART transmitter with TX FIFO, status register, GPIO output register).

Parameters:
- CLK_DIV, 16, clock cycles per UART bit (≥2)
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, ≥2)

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- addr  input  8  data address (CPU EX_MEM_rs_data)
- w_data  input  8  write data (CPU EX_MEM_rd_data)
- w_en  input  1  write strobe, one write per cycle while high (CPU EX_MEM_mem_w_en)
- r_data  output  8  combinational read data (to CPU mem_r_data)
- uart_txd  output  1  serial out, 8N1, LSB first, idle high
- gpio_out  output  8  GPIO output register

Behaviour:
- Reset (async assert, sync-safe deassert use): uart_txd=1, gpio_out=0x00, FIFO empty, overflow=0, FSM=IDLE, counters 0. RAM contents are not reset (undefined until written).
- Read: r_data is a pure combinational function of addr and current state; zero-cycle latency.
  - 0x00–0xEF: RAM byte.
  - 0xF0: 0x00.
  - 0xF1: status {5'b0, overflow, fifo_full, tx_busy}.
  - 0xF2: gpio_out.
  - 0xF3–0xFF: 0x00.
- Write (rising edge with w_en=1):
  - 0x00–0xEF: RAM byte updated. Same-cycle read of that address returns the old value.
  - 0xF0: push w_data into the FIFO. If the FIFO is full and no pop happens that edge, the byte is dropped and overflow is set (sticky). A push and pop on the same edge while full is accepted, with no overflow.
  - 0xF1: any value clears overflow. A simultaneous overflow event wins, so overflow stays 1.
  - 0xF2: gpio_out <= w_data.
  - 0xF3–0xFF: ignored.
- tx_busy = (FSM != IDLE) || FIFO non-empty. fifo_full = count == FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO non-empty, pop into the shift register, go to START, clear baud counter.
  - START: txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_DIV cycles per bit, shift right; after bit 7 go to STOP.
  - STOP: txd=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Latency: a push committed at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1. uart_txd falls at E+1 and the frame lasts exactly 10×CLK_DIV cycles.
- FIFO: circular, read/write pointers of log2(FIFO_DEPTH) bits wrapping modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: txd returns high immediately, the frame is aborted and the FIFO is flushed.

Decomposition:
- Shared package holds:
  - address constants: RAM_TOP=0xEF, ADDR_UART_DATA=0xF0, ADDR_UART_STAT=0xF1, ADDR_GPIO=0xF2
  - status bit indices: BUSY=0, FULL=1, OVF=2
  - the UART FSM state enum
- One sub-module, uart_tx_fifo, contains the FIFO, FSM and baud/bit counters.
  - Interface: push/data/full/busy/overflow-event/txd.
- The top level holds the RAM, address decode, gpio register and overflow flag.

Test Plan:
- RAM: write 0x5A @0x10, 0xA5 @0xEF, then read both → 0x5A, 0xA5. Read 0xF3 → 0x00. Write 0xFF @0xF5 → no state change.
- Single TX (CLK_DIV=4): write 0x55 @0xF0 at edge E → txd low E+1..E+4, then bits 1,0,1,0,1,0,1,0, stop high. Status reads 0x01 during the frame, 0x00 after 40 cycles.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles → three contiguous 40-cycle frames with no idle between them, decoded bytes 0x01, 0x02, 0x03.
- Overflow (FIFO_DEPTH=4): write 6 bytes in 6 consecutive cycles.
  - The first is popped and the next 4 fill the FIFO → status 0x07; the 6th byte is dropped.
  - Write @0xF1 → status 0x03.
  - Only 5 frames appear on txd.
- GPIO: write 0xC3 @0xF2 → gpio_out=0xC3 next cycle, read @0xF2=0xC3.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 → txd=1 and gpio_out=0x00 immediately. After release, status=0x00 and no further frame is sent.
